keccak_rc_lfsr_seq: RTL
=======================

Name: keccak_rc_lfsr_seq

Overview:
- Sequential, parametrised generator of Keccak round constants for any Keccak-p[b, nr] instance.
- Replaces a per-round lookup with the standard FIPS-202 rc(t) LFSR, advanced 7 steps per round.
- Emits the compressed 7-bit RC form (bit j = RC[2^j-1]) and the lane-width expanded RC, for 1..4 unrolled rounds per cycle.
- Sits beside the round datapath and is driven by the permutation controller through a start/advance handshake.

Parameters:
- NUM_ROUNDS, 24, rounds per permutation; must be a multiple of UNROLL; ROUND_OFFSET+NUM_ROUNDS <= 31.
- LANE_W, 64, lane width 2^L with L in 0..6; only RC bits j <= L are expanded.
- UNROLL, 1, rounds whose constants are presented per cycle; legal values 1..4.
- ROUND_OFFSET, 0, first round index ir0. Use 12 for Keccak-p[1600,12].

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous, active-low reset.
- start_i  in  1  begin a new permutation; also aborts a running one.
- adv_i  in  1  consumer has applied the current round group.
- valid_o  out  1  rc_o, rc_lane_o and round_idx_o are meaningful.
- rc_o  out  7*UNROLL  compressed constants; slice k = round round_idx_o+k.
- rc_lane_o  out  LANE_W*UNROLL  expanded constants; slice k = round round_idx_o+k.
- round_idx_o  out  5  round index of slice 0.
- last_o  out  1  current group is the final group.
- done_o  out  1  one-cycle pulse after the final group is accepted.
- rc_err_o  out  1  sticky self-check error (see Optional Feature).

Behaviour:
- One clock. Reset is synchronous, active-low, sampled on the rising edge of clk_i.
- Reset values:
  - state IDLE, LFSR = SEED, round counter = ROUND_OFFSET.
  - valid_o = 0, last_o = 0, done_o = 0, rc_err_o = 0.
  - rc_o = 0, rc_lane_o = 0, round_idx_o = 0.
- LFSR:
  - 8-bit state R, rc(0) seed R = 8'h01.
  - One step: shift left; the bit shifted out of bit 7 is XORed into bits 0, 4, 5, 6. rc(t) = R[0] after t steps.
  - Round ir, bit j = rc(j + 7*ir).
  - SEED is R advanced 7*ROUND_OFFSET steps, computed at elaboration by a constant function.
- Per cycle, combinational logic unrolls 7*UNROLL LFSR steps to form all UNROLL slices. The register updates to the state after 7*UNROLL steps.
- Expansion: rc_lane_o slice bit (2^j - 1) = rc_o slice bit j for 2^j - 1 < LANE_W; all other bits are 0.
- rc_o, rc_lane_o and round_idx_o are forced to 0 while valid_o = 0.
- FSM states:
  - IDLE: start_i -> RUN. LFSR loads SEED and the counter loads ROUND_OFFSET.
  - RUN: valid_o = 1.
    - adv_i, not the last group -> LFSR advances and the counter increments by UNROLL.
    - adv_i and last_o -> DONE.
    - adv_i = 0 -> all outputs hold (stall).
  - DONE: done_o = 1 for exactly one cycle and valid_o = 0. Next state IDLE, or RUN if start_i.
- last_o = valid_o & (counter + UNROLL == ROUND_OFFSET + NUM_ROUNDS).
- Latency:
  - start_i at cycle n -> valid_o = 1 at n+1, presenting round ROUND_OFFSET.
  - Each accepted adv_i presents the next group in the following cycle.
  - Minimum permutation: NUM_ROUNDS/UNROLL cycles of valid_o, then 1 done cycle.
- Simultaneous events:
  - start_i has priority over adv_i in every state. In RUN it reloads SEED; the aborted run produces no done_o.
  - adv_i is ignored in IDLE and DONE.
- Reset asserted mid-operation returns to IDLE on the next edge, with no done_o.

Optional Feature:
- Macro: KECCAK_RC_SELFCHECK_EN.
- Defined:
  - Adds a 32-entry constant table of compressed RCs for ir 0..31, generated at elaboration from the reference LFSR function.
  - Each valid cycle, every slice is compared with the table entry for its round.
  - Any mismatch sets rc_err_o. It is sticky and cleared only by reset or start_i.
- Undefined: rc_err_o is tied to 0 and the table is not instantiated.

Test Plan:
- Reset: hold rst_ni = 0 for 2 cycles with start_i = 1 -> valid_o = 0, done_o = 0, rc_o = 0, round_idx_o = 0, rc_err_o = 0.
- Defaults, start_i pulse then adv_i = 1 for 24 cycles:
  - rc_o sequence 0x01, 0x1A, 0x5E, 0x70, ... ending 0x74.
  - Round 1 rc_lane_o = 64'h0000000000008082; round 23 rc_lane_o = 64'h8000000080008008.
  - last_o high only at round 23; done_o single pulse one cycle later; rc_err_o = 0 with the macro defined.
- Stall at round 3 with adv_i = 0 for 5 cycles -> rc_o = 0x70 and round_idx_o = 3 hold. The resumed sequence continues with 0x1F.
- Restart: start_i asserted at round 10 (same cycle as adv_i) -> next cycle round_idx_o = 0, rc_o = 0x01; no done_o for the aborted run.
- LANE_W = 8, NUM_ROUNDS = 18: round 1 rc_lane_o = 8'h82, round 0 = 8'h01; done_o after 18 accepted advances.
- UNROLL = 2, ROUND_OFFSET = 12, NUM_ROUNDS = 12:
  - First valid cycle: round_idx_o = 12, rc_o[6:0] = 0x3F, rc_o[13:7] = 0x4F.
  - last_o on the 6th group; done_o after 6 accepted advances.

Source files
------------

// File: rtl/keccak_rc_lfsr_seq.sv
// Sequential Keccak-p round-constant generator built on the rc(t) LFSR, UNROLL rounds per cycle.
// Define KECCAK_RC_SELFCHECK_EN to compare each presented constant against an elaboration-time table.
module keccak_rc_lfsr_seq #(
  parameter int unsigned NUM_ROUNDS   = 24,
  parameter int unsigned LANE_W       = 64,
  parameter int unsigned UNROLL       = 1,
  parameter int unsigned ROUND_OFFSET = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       adv_i,
  output logic                       valid_o,
  output logic [7*UNROLL-1:0]        rc_o,
  output logic [LANE_W*UNROLL-1:0]   rc_lane_o,
  output logic [4:0]                 round_idx_o,
  output logic                       last_o,
  output logic                       done_o,
  output logic                       rc_err_o
);

  localparam int unsigned RC_W    = 7 * UNROLL;
  localparam int unsigned END_IDX = ROUND_OFFSET + NUM_ROUNDS;
  localparam logic [5:0]  END_IDX6 = 6'(END_IDX);
  localparam logic [4:0]  UNROLL5  = 5'(UNROLL);
  localparam logic [4:0]  OFFSET5  = 5'(ROUND_OFFSET);

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_adv(input logic [7:0] r, input int unsigned n);
    logic [7:0] s;
    s = r;
    for (int unsigned i = 0; i < n; i++) s = lfsr_step(s);
    return s;
  endfunction

  // Bit 7k+j of the result is rc(j + 7*(ir+k)) when r is the state at round ir.
  function automatic logic [RC_W-1:0] group_rc(input logic [7:0] r);
    logic [7:0]      s;
    logic [RC_W-1:0] rc;
    s  = r;
    rc = '0;
    for (int unsigned i = 0; i < RC_W; i++) begin
      rc[i] = s[0];
      s     = lfsr_step(s);
    end
    return rc;
  endfunction

  function automatic logic [LANE_W-1:0] expand(input logic [6:0] c);
    logic [LANE_W-1:0] l;
    l = '0;
    for (int unsigned b = 0; b < LANE_W; b++)
      for (int unsigned j = 0; j < 7; j++)
        if (b == (32'd1 << j) - 32'd1) l[b] = c[j];
    return l;
  endfunction

  localparam logic [7:0]      SEED       = lfsr_adv(8'h01, 7 * ROUND_OFFSET);
  localparam logic [7:0]      SEED_NEXT  = lfsr_adv(SEED, RC_W);
  localparam logic [RC_W-1:0] RC_FIRST   = group_rc(SEED);
  localparam logic            LAST_FIRST = (UNROLL == NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [4:0]      idx_q, idx_d, idx_nxt;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;

  // lfsr_q holds the LFSR state at the start of the group after the one presented.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      rc_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      rc_q    <= rc_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = '0;
    rc_d    = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    idx_nxt = idx_q + UNROLL5;
    unique case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        if (!adv_i) begin
          valid_d = 1'b1;
          rc_d    = rc_q;
          idx_d   = idx_q;
          last_d  = last_q;
        end else if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          lfsr_d  = lfsr_adv(lfsr_q, RC_W);
          rc_d    = group_rc(lfsr_q);
          idx_d   = idx_nxt;
          valid_d = 1'b1;
          last_d  = (({1'b0, idx_nxt} + {1'b0, UNROLL5}) == END_IDX6);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // start wins over adv in every state, including an abort of a running permutation
    if (start_i) begin
      state_d = RUN;
      lfsr_d  = SEED_NEXT;
      idx_d   = OFFSET5;
      rc_d    = RC_FIRST;
      valid_d = 1'b1;
      last_d  = LAST_FIRST;
      done_d  = 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign rc_o        = rc_q;
  assign round_idx_o = idx_q;
  assign last_o      = last_q;
  assign done_o      = done_q;

  always_comb begin
    rc_lane_o = '0;
    for (int unsigned k = 0; k < UNROLL; k++)
      rc_lane_o[k*LANE_W +: LANE_W] = expand(rc_q[7*k +: 7]);
  end

`ifdef KECCAK_RC_SELFCHECK_EN
  function automatic logic [32*7-1:0] gen_table();
    logic [32*7-1:0] t;
    logic [7:0]      s;
    t = '0;
    s = 8'h01;
    for (int unsigned i = 0; i < 32 * 7; i++) begin
      t[i] = s[0];
      s    = lfsr_step(s);
    end
    return t;
  endfunction

  localparam logic [32*7-1:0] RC_TABLE = gen_table();

  logic err_q;
  logic mism_c;

  always_comb begin
    mism_c = 1'b0;
    for (int unsigned k = 0; k < UNROLL; k++)
      if (valid_q && (rc_q[7*k +: 7] != RC_TABLE[7*(32'(idx_q) + k) +: 7])) mism_c = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)      err_q <= 1'b0;
    else if (start_i) err_q <= 1'b0;
    else if (mism_c)  err_q <= 1'b1;
  end

  assign rc_err_o = err_q;
`else
  assign rc_err_o = 1'b0;
`endif

endmodule
